// File: rtl/bus_pkg.sv
// Shared constants for the bus master mux: FSM and owner encodings, default widths
// and small grant-decoding helpers.
package bus_pkg;

   localparam int DEF_ADDR_W         = 8;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M1   = 2'd1,
      OWN_M2   = 2'd2,
      OWN_M3   = 2'd3
   } owner_t;

   // True when two or more grants are asserted at once.
   function automatic logic multi_ack(input logic [2:0] ack);
      return (ack[0] & ack[1]) | (ack[0] & ack[2]) | (ack[1] & ack[2]);
   endfunction

   function automatic owner_t ack_owner(input logic [2:0] ack);
      owner_t own;
      case (ack)
         3'b001:  own = OWN_M1;
         3'b010:  own = OWN_M2;
         3'b100:  own = OWN_M3;
         default: own = OWN_NONE;
      endcase
      return own;
   endfunction

   // OWN_NONE maps to no Done line at all.
   function automatic logic [2:0] owner_done(input owner_t own);
      logic [2:0] d;
      case (own)
         OWN_M1:  d = 3'b001;
         OWN_M2:  d = 3'b010;
         OWN_M3:  d = 3'b100;
         default: d = 3'b000;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent in ISSUE; expired is high on the last allowed cycle.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module bus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   assign expired = enable && (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/bus_master_mux.sv
// Latches the granted master's request, runs the slave valid/ready beat and returns
// Done/RData to the owner. Optional ISSUE timeout is enabled by BUS_TIMEOUT_EN.
module bus_master_mux
   import bus_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Ack1,
   input  logic              Ack2,
   input  logic              Ack3,
   input  logic              Start1,
   input  logic              Start2,
   input  logic              Start3,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [ADDR_W-1:0] Addr2,
   input  logic [ADDR_W-1:0] Addr3,
   input  logic [DATA_W-1:0] WData1,
   input  logic [DATA_W-1:0] WData2,
   input  logic [DATA_W-1:0] WData3,
   input  logic              Wr1,
   input  logic              Wr2,
   input  logic              Wr3,
   input  logic              BusReady,
   input  logic [DATA_W-1:0] BusRData,
   output logic              BusValid,
   output logic [ADDR_W-1:0] BusAddr,
   output logic [DATA_W-1:0] BusWData,
   output logic              BusWr,
   output logic              Done1,
   output logic              Done2,
   output logic              Done3,
   output logic [DATA_W-1:0] RData,
   output logic              Err,
   output logic              GrantErr,
   output logic [1:0]        dbg_state
);

   // Slave handshake: a beat completes on the cycle BusValid and BusReady are
   // both high; BusValid/BusAddr/BusWData/BusWr stay stable until then.

   state_t            state;
   owner_t            owner;
   logic [2:0]        done_q;
   logic              err_q;
   logic              timeout_hit;

   logic [2:0]        ack_vec;
   owner_t            grant_own;
   logic              sel_start;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_wr;

   assign ack_vec   = {Ack3, Ack2, Ack1};
   assign grant_own = ack_owner(ack_vec);

   always_comb begin
      sel_start = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wr    = 1'b0;
      case (grant_own)
         OWN_M1: begin
            sel_start = Start1;
            sel_addr  = Addr1;
            sel_wdata = WData1;
            sel_wr    = Wr1;
         end
         OWN_M2: begin
            sel_start = Start2;
            sel_addr  = Addr2;
            sel_wdata = WData2;
            sel_wr    = Wr2;
         end
         OWN_M3: begin
            sel_start = Start3;
            sel_addr  = Addr3;
            sel_wdata = WData3;
            sel_wr    = Wr3;
         end
         default: ;
      endcase
   end

`ifdef BUS_TIMEOUT_EN
   // Held clear outside ISSUE so every ISSUE entry starts from zero.
   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != ST_ISSUE),
      .enable  (state == ST_ISSUE),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         owner    <= OWN_NONE;
         BusValid <= 1'b0;
         BusAddr  <= '0;
         BusWData <= '0;
         BusWr    <= 1'b0;
         done_q   <= '0;
         err_q    <= 1'b0;
         RData    <= '0;
         GrantErr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= '0;
               err_q  <= 1'b0;
               if (multi_ack(ack_vec)) begin
                  GrantErr <= 1'b1;
               end else if (grant_own != OWN_NONE && sel_start) begin
                  owner    <= grant_own;
                  BusAddr  <= sel_addr;
                  BusWData <= sel_wdata;
                  BusWr    <= sel_wr;
                  BusValid <= 1'b1;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // A ready on the expiry cycle still counts as a normal completion.
               if (BusReady) begin
                  BusValid <= 1'b0;
                  if (!BusWr) RData <= BusRData;
                  done_q   <= owner_done(owner);
                  err_q    <= 1'b0;
                  state    <= ST_RESP;
               end else if (timeout_hit) begin
                  BusValid <= 1'b0;
                  RData    <= '0;
                  done_q   <= owner_done(owner);
                  err_q    <= 1'b1;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               done_q <= '0;
               err_q  <= 1'b0;
               owner  <= OWN_NONE;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Done1     = done_q[0];
   assign Done2     = done_q[1];
   assign Done3     = done_q[2];
   assign Err       = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_bus_master_mux.sv
// Directed scoreboard bench for bus_master_mux: completions are queued as
// {done_vec, err, rdata} and checked by a monitor whenever a Done pulse appears.
module tb_bus_master_mux;
   import bus_pkg::*;

   localparam int W = 12;

   logic       clk;
   logic       reset;
   logic       Ack1, Ack2, Ack3;
   logic       Start1, Start2, Start3;
   logic [7:0] Addr1, Addr2, Addr3;
   logic [7:0] WData1, WData2, WData3;
   logic       Wr1, Wr2, Wr3;
   logic       BusReady;
   logic [7:0] BusRData;
   logic       BusValid;
   logic [7:0] BusAddr;
   logic [7:0] BusWData;
   logic       BusWr;
   logic       Done1, Done2, Done3;
   logic [7:0] RData;
   logic       Err;
   logic       GrantErr;
   logic [1:0] dbg_state;

   logic [W-1:0] exp_q[$];
   logic [7:0]   model_rdata;
   int           total;
   int           bad;

   bus_master_mux dut (
      .clk(clk), .reset(reset),
      .Ack1(Ack1), .Ack2(Ack2), .Ack3(Ack3),
      .Start1(Start1), .Start2(Start2), .Start3(Start3),
      .Addr1(Addr1), .Addr2(Addr2), .Addr3(Addr3),
      .WData1(WData1), .WData2(WData2), .WData3(WData3),
      .Wr1(Wr1), .Wr2(Wr2), .Wr3(Wr3),
      .BusReady(BusReady), .BusRData(BusRData),
      .BusValid(BusValid), .BusAddr(BusAddr), .BusWData(BusWData), .BusWr(BusWr),
      .Done1(Done1), .Done2(Done2), .Done3(Done3),
      .RData(RData), .Err(Err), .GrantErr(GrantErr), .dbg_state(dbg_state)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] oh(input int m);
      logic [2:0] r;
      r = 3'b001;
      return r << (m - 1);
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset && (Done1 || Done2 || Done3)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got %b want none", {Done3, Done2, Done1});
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("done_vec", {29'd0, Done3, Done2, Done1}, {29'd0, e[11:9]});
            check("err", {31'd0, Err}, {31'd0, e[8]});
            check("rdata", {24'd0, RData}, {24'd0, e[7:0]});
         end
      end
   end

   // driver tasks
   task automatic clear_masters();
      Ack1 = 0; Ack2 = 0; Ack3 = 0;
      Start1 = 0; Start2 = 0; Start3 = 0;
   endtask

   task automatic set_master(input int m, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic wr);
      case (m)
         1: begin Ack1 = 1; Start1 = 1; Addr1 = addr; WData1 = wdata; Wr1 = wr; end
         2: begin Ack2 = 1; Start2 = 1; Addr2 = addr; WData2 = wdata; Wr2 = wr; end
         default: begin Ack3 = 1; Start3 = 1; Addr3 = addr; WData3 = wdata; Wr3 = wr; end
      endcase
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!BusValid && n < 10);
      check(name, {31'd0, BusValid}, 32'd1);
   endtask

   task automatic do_xfer(input int m, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic wr, input logic [7:0] rd, input int wait_cyc,
                          input bit switch_ack);
      logic [7:0] exp_rd;
      exp_rd      = wr ? model_rdata : rd;
      model_rdata = exp_rd;
      exp_q.push_back({oh(m), 1'b0, exp_rd});
      set_master(m, addr, wdata, wr);
      wait_valid("issue_valid");
      clear_masters();
      if (switch_ack) begin
         Ack3 = 1; Start3 = 1;
      end
      check("bus_addr", {24'd0, BusAddr}, {24'd0, addr});
      check("bus_wr", {31'd0, BusWr}, {31'd0, wr});
      if (wr) check("bus_wdata", {24'd0, BusWData}, {24'd0, wdata});
      repeat (wait_cyc) begin
         @(negedge clk);
         check("hold_valid", {31'd0, BusValid}, 32'd1);
         check("hold_addr", {24'd0, BusAddr}, {24'd0, addr});
         if (wr) check("hold_wdata", {24'd0, BusWData}, {24'd0, wdata});
      end
      BusReady = 1;
      BusRData = rd;
      @(negedge clk);
      BusReady = 0;
      clear_masters();
      @(negedge clk);
      check("valid_drop", {31'd0, BusValid}, 32'd0);
   endtask

   // main stimulus
   initial begin
      int cnt;
      int last_done;
      int ndone;
      total = 0;
      bad   = 0;
      model_rdata = 8'h00;
      clear_masters();
      Addr1 = 0; Addr2 = 0; Addr3 = 0;
      WData1 = 0; WData2 = 0; WData3 = 0;
      Wr1 = 0; Wr2 = 0; Wr3 = 0;
      BusReady = 0;
      BusRData = 0;
      reset = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, BusValid}, 32'd0);
      check("rst_done", {29'd0, Done3, Done2, Done1}, 32'd0);
      check("rst_rdata", {24'd0, RData}, 32'd0);
      check("rst_err", {30'd0, Err, GrantErr}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      reset = 1;
      @(negedge clk);

      // 1: read for master 2, ready two cycles after valid
      do_xfer(2, 8'h3C, 8'h00, 1'b0, 8'hA5, 2, 1'b0);
      // 2: write for master 1 with grant moving to master 3 mid-transfer
      do_xfer(1, 8'h81, 8'h5A, 1'b1, 8'hFF, 3, 1'b1);
      repeat (2) @(negedge clk);
      check("no_spurious_valid", {31'd0, BusValid}, 32'd0);

      // 3: two grants at once
      Ack1 = 1; Ack3 = 1; Start1 = 1; Start3 = 1;
      repeat (3) begin
         @(negedge clk);
         check("multi_no_valid", {31'd0, BusValid}, 32'd0);
      end
      check("grant_err_set", {31'd0, GrantErr}, 32'd1);
      clear_masters();
      repeat (3) @(negedge clk);
      check("grant_err_sticky", {31'd0, GrantErr}, 32'd1);

`ifdef BUS_TIMEOUT_EN
      // 4a: no ready -> abort after 16 cycles of BusValid
      exp_q.push_back({3'b001, 1'b1, 8'h00});
      model_rdata = 8'h00;
      BusRData = 8'hEE;
      set_master(1, 8'h10, 8'h00, 1'b0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (BusValid) begin
            cnt++;
            clear_masters();
         end else if (cnt > 0) begin
            break;
         end
      end
      check("timeout_valid_cycles", cnt, 32'd16);
      repeat (2) @(negedge clk);
      // 4b: ready on the expiry cycle completes normally
      do_xfer(1, 8'h11, 8'h00, 1'b0, 8'h77, 15, 1'b0);
`else
      // 4: without the timeout, ISSUE waits as long as the slave stalls
      do_xfer(1, 8'h10, 8'h00, 1'b0, 8'h77, 30, 1'b0);
`endif

      // 5: reset during ISSUE
      set_master(2, 8'h44, 8'h00, 1'b0);
      wait_valid("pre_reset_valid");
      @(negedge clk);
      reset = 0;
      #1;
      check("async_valid_drop", {31'd0, BusValid}, 32'd0);
      check("async_done_drop", {29'd0, Done3, Done2, Done1}, 32'd0);
      check("async_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      clear_masters();
      model_rdata = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      check("grant_err_cleared", {31'd0, GrantErr}, 32'd0);
      check("post_reset_rdata", {24'd0, RData}, 32'd0);
      do_xfer(2, 8'h22, 8'h00, 1'b0, 8'h99, 1, 1'b0);
      do_xfer(3, 8'h40, 8'h66, 1'b1, 8'h12, 0, 1'b0);

      // 6: back-to-back master 3 reads with the slave always ready
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) exp_q.push_back({3'b100, 1'b0, 8'hC3});
      model_rdata = 8'hC3;
      BusReady = 1;
      BusRData = 8'hC3;
      set_master(3, 8'h5E, 8'h00, 1'b0);
      ndone = 0;
      last_done = -1;
      for (int c = 0; c < 40 && ndone < 4; c++) begin
         @(negedge clk);
         if (Done3) begin
            if (last_done >= 0) check("b2b_spacing", c - last_done, 32'd3);
            last_done = c;
            ndone++;
            if (ndone == 4) clear_masters();
         end
      end
      check("b2b_count", ndone, 32'd4);
      BusReady = 0;
      repeat (6) @(negedge clk);
      check("b2b_idle", {31'd0, BusValid}, 32'd0);

      // report
      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
